// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Purpose : Types and helpers shared by the down_counter block.
// Contents: state_t - control FSM encoding (IDLE=0, RUN=1, DONE=2, 2 bits)
//           is_one  - detects the last count before the terminal value.
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The terminal decision happens one step early: q==1 is the last value the
  // counter shows before reaching 0 (or before reloading).
  function automatic logic is_one(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value & mask) == 32'd1;
  endfunction

endpackage

// File: rtl/down_counter_core.sv
// -----------------------------------------------------------------------------
// down_counter_core
// Purpose : Loadable, decrementing count register. All bits update together on
//           the falling edge of clk; no bit is clocked by another bit.
// Ports   : clk    - clock (state changes on negedge)
//           reset  - synchronous active-high clear
//           i_wr   - write i_din into the register (priority over i_dec)
//           i_din  - value written when i_wr=1
//           i_dec  - decrement by one
//           o_q    - registered count
// -----------------------------------------------------------------------------
module down_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_wr) begin
      r_q <= i_din;
    end else if (i_dec) begin
      r_q <= r_q - WIDTH'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Purpose : Loadable down counter with IDLE/RUN/DONE control, optional
//           auto-reload on terminal count and a registered one-cycle tc pulse.
// Params  : WIDTH       - counter width in bits
//           AUTO_RELOAD - 1: reload the last loaded value when the count ends
// Ports   : clk      - clock, all state changes on the falling edge
//           reset    - synchronous active-high reset
//           load     - load load_val (priority over en in every state)
//           load_val - start value, sampled only when load=1
//           en       - count enable (ignored outside RUN)
//           q        - registered count
//           tc       - registered terminal-count pulse
//           busy     - state is RUN
//           done     - state is DONE
// -----------------------------------------------------------------------------
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic             r_tc;
  logic [WIDTH-1:0] r_reload;

  logic [WIDTH-1:0] w_q;
  logic             w_at_one;
  logic             w_step;
  logic             w_reload;
  logic             w_core_wr;
  logic [WIDTH-1:0] w_core_din;
  logic             w_core_dec;

  assign w_at_one = is_one(32'(w_q), WIDTH);
  assign w_step   = (r_state == ST_RUN) && en;

  // Auto-reload replaces the 1 -> 0 step so q never shows 0 while running.
  assign w_reload   = w_step && w_at_one && AUTO_RELOAD;
  assign w_core_wr  = load || w_reload;
  assign w_core_din = load ? load_val : r_reload;
  assign w_core_dec = w_step && !w_reload;

  down_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .i_wr  (w_core_wr),
    .i_din (w_core_din),
    .i_dec (w_core_dec),
    .o_q   (w_q)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_tc     <= 1'b0;
      r_reload <= '0;
    end else if (load) begin
      // A load also wins over a coinciding terminal count: no tc pulse.
      r_reload <= load_val;
      r_tc     <= 1'b0;
      r_state  <= (load_val != '0) ? ST_RUN : ST_DONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tc <= r_tc;
        end
        ST_RUN: begin
          if (w_step && w_at_one) begin
            r_tc    <= 1'b1;
            r_state <= AUTO_RELOAD ? ST_RUN : ST_DONE;
          end else begin
            r_tc <= 1'b0;
          end
        end
        ST_DONE: begin
          r_tc <= 1'b0;
        end
        default: begin
          r_tc    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = w_q;
  assign tc   = r_tc;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } row_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;

  logic [3:0] q0, q1;
  logic       tc0, tc1, busy0, busy1, done0, done1;
  logic [6:0] obs0, obs1;

  logic [6:0] sb[$];
  int         n_run;
  int         n_fail;

  assign obs0 = {q0, tc0, busy0, done0};
  assign obs1 = {q1, tc1, busy1, done1};

  down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .q(q0), .tc(tc0), .busy(busy0), .done(done0)
  );

  down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .q(q1), .tc(tc1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input bit rst, input bit ld, input int lv,
                              input bit e, input int eq, input bit etc,
                              input bit ebusy, input bit edone);
    row_t r;
    r.rst  = rst;
    r.ld   = ld;
    r.lv   = 4'(lv);
    r.en   = e;
    r.q    = 4'(eq);
    r.tc   = etc;
    r.busy = ebusy;
    r.done = edone;
    return r;
  endfunction

  // Drives one cycle of stimulus on the inactive (rising) edge and queues the
  // outputs expected after the following falling edge.
  task automatic drive_row(input row_t r);
    @(posedge clk);
    reset    = r.rst;
    load     = r.ld;
    load_val = r.lv;
    en       = r.en;
    sb.push_back({r.q, r.tc, r.busy, r.done});
  endtask

  task automatic test_reset();
    row_t       rows [4];
    logic [6:0] exp_v;
    rows[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    rows[1] = mk(1, 1, 5, 1, 0, 0, 0, 0);
    rows[2] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    rows[3] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs0 !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d] dut0 {q,tc,busy,done} got %b want %b", i, obs0, exp_v);
      end
      n_run++;
      if (obs1 !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d] dut1 {q,tc,busy,done} got %b want %b", i, obs1, exp_v);
      end
    end
  endtask

  task automatic test_count();
    row_t       rows [11];
    logic [6:0] exp_v;
    rows[0]  = mk(0, 1, 5, 1, 5, 0, 1, 0);
    rows[1]  = mk(0, 0, 0, 1, 4, 0, 1, 0);
    rows[2]  = mk(0, 0, 0, 1, 3, 0, 1, 0);
    rows[3]  = mk(0, 0, 0, 1, 2, 0, 1, 0);
    rows[4]  = mk(0, 0, 0, 1, 1, 0, 1, 0);
    rows[5]  = mk(0, 0, 0, 1, 0, 1, 0, 1);
    for (int k = 6; k < 11; k++) rows[k] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs0 !== exp_v) begin
        n_fail++;
        $display("FAIL count[%0d] {q,tc,busy,done} got %b want %b", i, obs0, exp_v);
      end
    end
  endtask

  task automatic test_en_toggle();
    row_t       rows [7];
    logic [6:0] exp_v;
    rows[0] = mk(0, 1, 3, 1, 3, 0, 1, 0);
    rows[1] = mk(0, 0, 0, 1, 2, 0, 1, 0);
    rows[2] = mk(0, 0, 0, 0, 2, 0, 1, 0);
    rows[3] = mk(0, 0, 0, 0, 2, 0, 1, 0);
    rows[4] = mk(0, 0, 0, 1, 1, 0, 1, 0);
    rows[5] = mk(0, 0, 0, 1, 0, 1, 0, 1);
    rows[6] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs0 !== exp_v) begin
        n_fail++;
        $display("FAIL en_toggle[%0d] {q,tc,busy,done} got %b want %b", i, obs0, exp_v);
      end
    end
  endtask

  task automatic test_autoreload();
    row_t       rows [14];
    logic [6:0] exp_v;
    int         seq [8] = '{2, 1, 3, 2, 1, 3, 2, 1};
    rows[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    rows[1] = mk(0, 1, 3, 1, 3, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      rows[2+k] = mk(0, 0, 0, 1, seq[k], (seq[k] == 3), 1, 0);
    // Reload value 1: tc legitimately stays high on consecutive cycles.
    rows[10] = mk(0, 1, 1, 1, 1, 0, 1, 0);
    rows[11] = mk(0, 0, 0, 1, 1, 1, 1, 0);
    rows[12] = mk(0, 0, 0, 1, 1, 1, 1, 0);
    rows[13] = mk(0, 0, 0, 0, 1, 0, 1, 0);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs1 !== exp_v) begin
        n_fail++;
        $display("FAIL autoreload[%0d] {q,tc,busy,done} got %b want %b", i, obs1, exp_v);
      end
    end
  endtask

  task automatic test_load_zero();
    row_t       rows [5];
    logic [6:0] exp_v;
    rows[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    rows[1] = mk(0, 1, 0, 1, 0, 0, 0, 1);
    rows[2] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    rows[3] = mk(0, 1, 15, 0, 15, 0, 1, 0);
    rows[4] = mk(0, 0, 0, 1, 14, 0, 1, 0);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs0 !== exp_v) begin
        n_fail++;
        $display("FAIL load_zero[%0d] {q,tc,busy,done} got %b want %b", i, obs0, exp_v);
      end
    end
  endtask

  task automatic test_reset_midcount();
    row_t       rows [7];
    logic [6:0] exp_v;
    rows[0] = mk(0, 1, 9, 1, 9, 0, 1, 0);
    rows[1] = mk(0, 0, 0, 1, 8, 0, 1, 0);
    rows[2] = mk(0, 0, 0, 1, 7, 0, 1, 0);
    rows[3] = mk(0, 0, 0, 1, 6, 0, 1, 0);
    rows[4] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    rows[5] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    rows[6] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs0 !== exp_v) begin
        n_fail++;
        $display("FAIL reset_midcount[%0d] {q,tc,busy,done} got %b want %b", i, obs0, exp_v);
      end
    end
  endtask

  task automatic test_load_at_tc();
    row_t       rows [4];
    logic [6:0] exp_v;
    rows[0] = mk(0, 1, 2, 1, 2, 0, 1, 0);
    rows[1] = mk(0, 0, 0, 1, 1, 0, 1, 0);
    rows[2] = mk(0, 1, 7, 1, 7, 0, 1, 0);
    rows[3] = mk(0, 0, 0, 1, 6, 0, 1, 0);
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk); #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs0 !== exp_v) begin
        n_fail++;
        $display("FAIL load_at_tc[%0d] dut0 {q,tc,busy,done} got %b want %b", i, obs0, exp_v);
      end
      n_run++;
      if (obs1 !== exp_v) begin
        n_fail++;
        $display("FAIL load_at_tc[%0d] dut1 {q,tc,busy,done} got %b want %b", i, obs1, exp_v);
      end
    end
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    en       = 1'b0;

    test_reset();
    test_count();
    test_en_toggle();
    test_autoreload();
    test_load_zero();
    test_reset_midcount();
    test_load_at_tc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The module SHALL have parameter AUTO_RELOAD, default 0; 1 selects auto-reload on terminal count.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on the negative edge of clk.
REQ-004 Port reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port load  input  1  SHALL request loading load_val into the counter.
REQ-006 Port load_val  input  WIDTH  SHALL be the start value, sampled only when load=1.
REQ-007 Port en  input  1  SHALL be the count enable.
REQ-008 Port q  output  WIDTH  SHALL be the registered current count.
REQ-009 Port tc  output  1  SHALL be the registered one-cycle terminal-count pulse.
REQ-010 Port busy  output  1  SHALL be high while the state is RUN.
REQ-011 Port done  output  1  SHALL be high while the state is DONE.

Function
REQ-012 The counter SHALL be fully synchronous: all bits change on the same clk edge, with no bit clocked by another bit.
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 A reload register SHALL capture load_val on every accepted load.
REQ-015 load=1 SHALL take priority over en in every state.
REQ-016 On load with load_val!=0: q<=load_val, next state RUN.
REQ-017 On load with load_val==0: q<=0, next state DONE, tc stays 0.
REQ-018 IDLE without load: q, tc and the state SHALL hold.
REQ-019 RUN, en=0, no load: q SHALL hold and tc<=0.
REQ-020 RUN, en=1, q>1, no load: q<=q-1 and tc<=0.
REQ-021 RUN, en=1, q==1, AUTO_RELOAD=0: q<=0, tc<=1, next state DONE.
REQ-022 RUN, en=1, q==1, AUTO_RELOAD=1: q<=reload register, tc<=1, stay RUN; q never shows 0.
REQ-023 DONE without load: q holds 0, tc<=0, state holds; en SHALL be ignored and q SHALL NOT wrap to all-ones.
REQ-024 Latency: q SHALL reflect load_val or a decrement one clk edge after the sampling edge.
REQ-025 tc SHALL be high in the same cycle that q first shows the terminal or reloaded value.
REQ-026 tc SHALL never be high for two consecutive cycles unless the reload value is 1 under auto-reload.
REQ-027 Load coinciding with terminal count SHALL apply the load; tc<=0.
REQ-028 busy and done SHALL be decoded from the registered state, never both high.

Reset
REQ-029 reset=1 at a clk edge SHALL force q=0, tc=0, the reload register to 0 and the state to IDLE (busy=0, done=0).
REQ-030 reset SHALL override load and en.
REQ-031 Reset asserted mid-count SHALL abort the count with no tc pulse.
REQ-032 After release, the counter SHALL remain in IDLE until the first load.

Structure
REQ-033 The state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) SHALL reside in the shared package counter_pkg.
REQ-034 A sub-module down_counter_core SHALL implement the loadable/decrementing register; the FSM, reload register and tc logic SHALL live in down_counter.

Verification
REQ-035 WIDTH=4, AUTO_RELOAD=0; reset 2 cycles, then load 5, en=1 -> q = 5,4,3,2,1,0; tc=1 only in the cycle q=0; done=1 thereafter; q stays 0 for 5 more cycles.
REQ-036 Load 3; en toggles 1,0,0,1,1 -> q = 3,2,2,2,1,0; busy=1 until DONE.
REQ-037 AUTO_RELOAD=1; load 3, en=1 for 9 cycles -> q = 3,2,1,3,2,1,3,2,1; tc=1 in each cycle q returns to 3.
REQ-038 Load 0 -> q=0, done=1, tc=0 throughout; then load 15 -> q=15, busy=1.
REQ-039 Load 9, count to 6, assert reset for 1 cycle -> q=0, IDLE, no tc; en alone does not restart counting.
REQ-040 In RUN at q==1 with en=1 and load=1, load_val=7 -> q=7, tc=0, state RUN.
